// File: rtl/hex_display_driver.sv
// Multiplexed 8-digit 7-segment driver for the lab board: shows a 32-bit hex value
// with tear-free frame updates, leading-zero blanking and per-digit decimal points.
module hex_display_driver #(
   parameter int REFRESH_DIV = 100000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] value,
   input  logic        load,
   input  logic [7:0]  dp_mask,
   input  logic [7:0]  digit_en,
   input  logic        blank_lz,
   output logic [7:0]  anodes,
   output logic [6:0]  segments,
   output logic        dp,
   output logic        frame_done
);

   localparam int PW = $clog2(REFRESH_DIV);
   localparam logic [PW-1:0] LAST = PW'(REFRESH_DIV - 1);

   logic [PW-1:0] prescaler;
   logic [2:0]    idx;
   logic          tick;
   logic          wrap;

   logic [31:0] shadow_value;
   logic [7:0]  shadow_dp;
   logic        pending;
   logic [31:0] active_value;
   logic [7:0]  active_dp;

   logic [7:0]  blanked;
   logic        zero_run;
   logic        lit;
   logic [3:0]  nibble;
   logic [7:0]  anodes_next;
   logic [6:0]  segments_next;
   logic        dp_next;

   function automatic logic [6:0] hex_decode(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   assign tick = (prescaler == LAST);
   assign wrap = tick && (idx == 3'd7);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         prescaler  <= '0;
         idx        <= 3'd0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= wrap;
         if (tick) begin
            prescaler <= '0;
            idx       <= idx + 3'd1;
         end else begin
            prescaler <= prescaler + PW'(1);
         end
      end
   end

   // Active only changes at the frame boundary; a load in the wrap cycle goes straight through.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         shadow_value <= 32'd0;
         shadow_dp    <= 8'd0;
         pending      <= 1'b0;
         active_value <= 32'd0;
         active_dp    <= 8'd0;
      end else begin
         if (load) begin
            shadow_value <= value;
            shadow_dp    <= dp_mask;
         end
         if (wrap) begin
            pending <= 1'b0;
            if (load) begin
               active_value <= value;
               active_dp    <= dp_mask;
            end else if (pending) begin
               active_value <= shadow_value;
               active_dp    <= shadow_dp;
            end
         end else if (load) begin
            pending <= 1'b1;
         end
      end
   end

   always_comb begin
      blanked  = 8'd0;
      zero_run = 1'b1;
      for (int k = 7; k >= 1; k--) begin
         zero_run   = zero_run && (active_value[4*k +: 4] == 4'd0);
         blanked[k] = blank_lz && zero_run;
      end
   end

   always_comb begin
      nibble        = active_value[{idx, 2'b00} +: 4];
      lit           = digit_en[idx] && !blanked[idx];
      anodes_next   = 8'hFF;
      segments_next = 7'h7F;
      dp_next       = 1'b1;
      if (lit) begin
         anodes_next[idx] = 1'b0;
         segments_next    = hex_decode(nibble);
         dp_next          = ~active_dp[idx];
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         anodes   <= 8'hFF;
         segments <= 7'h7F;
         dp       <= 1'b1;
      end else begin
         anodes   <= anodes_next;
         segments <= segments_next;
         dp       <= dp_next;
      end
   end

endmodule

// File: tb/tb_hex_display_driver.sv
// Bench for hex_display_driver: directed frame scenarios followed by random loads,
// checked every cycle against a frame-level model of the display.
module tb_hex_display_driver;

   localparam int DIV   = 4;
   localparam int FRAME = 8 * DIV;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] value = 32'd0;
   logic        load = 1'b0;
   logic [7:0]  dp_mask = 8'd0;
   logic [7:0]  digit_en = 8'hFF;
   logic        blank_lz = 1'b0;
   logic [7:0]  anodes;
   logic [6:0]  segments;
   logic        dp;
   logic        frame_done;

   int total = 0;
   int bad = 0;
   int k = 0;

   logic [31:0] m_shadow;
   logic [7:0]  m_sdp;
   logic        m_pending;
   logic [31:0] m_active;
   logic [7:0]  m_adp;

   logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   hex_display_driver #(.REFRESH_DIV(DIV)) dut (
      .clock(clock), .reset(reset), .value(value), .load(load), .dp_mask(dp_mask),
      .digit_en(digit_en), .blank_lz(blank_lz), .anodes(anodes), .segments(segments),
      .dp(dp), .frame_done(frame_done)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s at step %0d: got %0h want %0h", tag, k, obs, exp);
      end
   endtask

   task automatic model_reset();
      k = 0;
      m_shadow = 32'd0;
      m_sdp = 8'd0;
      m_pending = 1'b0;
      m_active = 32'd0;
      m_adp = 8'd0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_anodes"}, {24'd0, anodes}, 32'hFF);
      check({tag, "_segments"}, {25'd0, segments}, 32'h7F);
      check({tag, "_dp"}, {31'd0, dp}, 32'd1);
      check({tag, "_frame_done"}, {31'd0, frame_done}, 32'd0);
   endtask

   // One clock: predict the slot shown after this edge, advance the model, compare.
   task automatic step();
      int i;
      logic [31:0] upper;
      logic lit;
      logic wrap;
      logic [7:0] ea;
      logic [6:0] es;
      logic edp;
      k++;
      i = ((k - 1) / DIV) % 8;
      upper = m_active >> (4 * i);
      lit = digit_en[i] && !(blank_lz && i > 0 && upper == 32'd0);
      ea = 8'hFF;
      es = 7'h7F;
      edp = 1'b1;
      if (lit) begin
         ea[i] = 1'b0;
         es = seg_tab[upper[3:0]];
         edp = ~m_adp[i];
      end
      wrap = (k % FRAME == 0);
      if (wrap) begin
         if (load) begin
            m_active = value;
            m_adp = dp_mask;
         end else if (m_pending) begin
            m_active = m_shadow;
            m_adp = m_sdp;
         end
         m_pending = 1'b0;
      end else if (load) begin
         m_pending = 1'b1;
      end
      if (load) begin
         m_shadow = value;
         m_sdp = dp_mask;
      end
      @(posedge clock);
      #1;
      check("anodes", {24'd0, anodes}, {24'd0, ea});
      check("segments", {25'd0, segments}, {25'd0, es});
      check("dp", {31'd0, dp}, {31'd0, edp});
      check("frame_done", {31'd0, frame_done}, {31'd0, wrap});
      check("one_anode", {31'd0, ($countones(~anodes) <= 1)}, 32'd1);
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic do_load(input logic [31:0] v, input logic [7:0] m);
      value = v;
      dp_mask = m;
      load = 1'b1;
      step();
      load = 1'b0;
   endtask

   task automatic align_to(input int r);
      repeat (FRAME) if (k % FRAME != r) step();
   endtask

   task automatic pulse_reset();
      reset = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      @(posedge clock);
      #1;
      check_reset_outputs("held_reset");
      reset = 1'b1;
      model_reset();
   endtask

   initial begin
      logic [31:0] rv;
      model_reset();
      #2;
      reset = 1'b0;
      #1;
      check_reset_outputs("reset");
      @(posedge clock);
      #1;
      reset = 1'b1;

      run(2 * FRAME + 3);

      do_load(32'h89ABCDEF, 8'h00);
      run(2 * FRAME);

      align_to(5);
      do_load(32'h12345678, 8'h00);
      run(7);
      do_load(32'h0000000F, 8'h00);
      run(2 * FRAME);

      blank_lz = 1'b1;
      do_load(32'h00000A00, 8'h00);
      run(2 * FRAME);
      do_load(32'h00000000, 8'h00);
      run(2 * FRAME);
      blank_lz = 1'b0;

      digit_en = 8'hFB;
      do_load(32'h00000000, 8'h04);
      run(2 * FRAME);
      digit_en = 8'hFF;
      run(FRAME);

      align_to(FRAME - 1);
      do_load(32'hCAFE0123, 8'hA5);
      run(FRAME + 2);

      do_load(32'hDEADBEEF, 8'hFF);
      run(9);
      pulse_reset();
      run(2 * FRAME + 1);

      for (int n = 0; n < 20 * FRAME; n++) begin
         if (n % 64 == 0) begin
            digit_en = 8'($urandom);
            blank_lz = 1'($urandom);
         end
         if ($urandom_range(0, 15) == 0) begin
            rv = $urandom;
            rv = rv >> (4 * $urandom_range(0, 8));
            do_load(rv, 8'($urandom));
         end else begin
            step();
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
